// File: rtl/cover_sched_pkg.sv
// Shared constants and types for the toggle-coverage scheduler.
// Holds the cover-index width, the valid index range and the index type.
package cover_sched_pkg;
    localparam int IDX_W       = 64;
    localparam int COVER_TOTAL = 8744;

    typedef logic [IDX_W-1:0] cover_idx_t;
endpackage

// File: rtl/cover_toggle_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at/after ptr_i, wrapping.
// Ports: req_i request vector, ptr_i start position, grant_o one-hot, idx_o encoded.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o
);
    always_comb begin
        logic found;
        found   = 1'b0;
        grant_o = '0;
        idx_o   = '0;
        for (int i = 0; i < N; i++) begin
            int j;
            j = (int'(ptr_i) + i) % N;
            if (!found && req_i[j]) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = IW'(j);
            end
        end
    end
endmodule

// File: rtl/cover_toggle_sched.sv
// Serialises pending toggle-coverage hits from all groups into one index stream.
// Ports: gbl_clk/reset, grp_valid/grp_base in, clear, out_* handshake, drop_cnt,
// range_err, busy.
module cover_toggle_sched
    import cover_sched_pkg::*;
#(
    parameter int NUM_GROUPS = 4,
    parameter int GROUP_W    = 7,
    parameter bit DEDUP      = 1'b1
) (
    input  logic                          gbl_clk,
    input  logic                          reset,
    input  logic [NUM_GROUPS*GROUP_W-1:0] grp_valid,
    input  logic [NUM_GROUPS*IDX_W-1:0]   grp_base,
    input  logic                          clear,
    output logic                          out_valid,
    input  logic                          out_ready,
    output cover_idx_t                    out_index,
    output logic [15:0]                   drop_cnt,
    output logic                          range_err,
    output logic                          busy
);
    localparam int NB = NUM_GROUPS * GROUP_W;
    localparam int PW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int BW = (GROUP_W > 1) ? $clog2(GROUP_W) : 1;

    logic [NB-1:0]         pending_q, pending_d;
    logic [NB-1:0]         reported_q, reported_d;
    logic                  out_valid_q, out_valid_d;
    cover_idx_t            out_index_q, out_index_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;
    logic                  range_err_q, range_err_d;
    logic [PW-1:0]         ptr_q, ptr_d;

    logic [NUM_GROUPS-1:0] req;
    logic [NUM_GROUPS-1:0] gnt;
    logic [PW-1:0]         gidx;
    logic [GROUP_W-1:0]    grp_bits;
    logic [BW-1:0]         bit_idx;
    logic                  load;
    logic                  take;
    logic [NB-1:0]         grant_clr;
    logic [NB-1:0]         hit_mask;
    logic                  merge;
    cover_idx_t            new_idx;

    always_comb begin
        for (int g = 0; g < NUM_GROUPS; g++) begin
            req[g] = |pending_q[g*GROUP_W +: GROUP_W];
        end
    end

    rr_arbiter #(.N(NUM_GROUPS)) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (gnt),
        .idx_o   (gidx)
    );

    always_comb begin
        grp_bits = pending_q[gidx*GROUP_W +: GROUP_W];
        bit_idx  = '0;
        for (int i = GROUP_W - 1; i >= 0; i--) begin
            if (grp_bits[i]) bit_idx = BW'(i);
        end
    end

    assign load    = !out_valid_q || out_ready;
    // No new grant during clear: only the in-flight beat may retire.
    assign take    = load && (|req) && !clear;
    assign new_idx = grp_base[gidx*IDX_W +: IDX_W] + cover_idx_t'(bit_idx);

    always_comb begin
        for (int g = 0; g < NUM_GROUPS; g++) begin
            grant_clr[g*GROUP_W +: GROUP_W] =
                (take && gnt[g]) ? (GROUP_W'(1) << bit_idx) : '0;
        end
    end

    // With dedup, a hit landing on the bit granted this cycle is already
    // covered by that grant, so it is masked like a reported bit.
    assign hit_mask = DEDUP ? (grp_valid & ~(reported_q | grant_clr))
                            : grp_valid;
    assign merge    = |(grp_valid & pending_q & ~grant_clr);

    always_comb begin
        pending_d   = pending_q;
        reported_d  = reported_q;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        drop_cnt_d  = drop_cnt_q;
        range_err_d = range_err_q;
        ptr_d       = ptr_q;
        if (clear) begin
            pending_d  = '0;
            reported_d = '0;
            drop_cnt_d = '0;
            if (out_ready) out_valid_d = 1'b0;
        end else begin
            pending_d  = (pending_q & ~grant_clr) | hit_mask;
            reported_d = reported_q | grant_clr;
            if (merge && drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
            if (take) begin
                out_valid_d = 1'b1;
                out_index_d = new_idx;
                ptr_d = (gidx == PW'(NUM_GROUPS - 1)) ? '0 : gidx + PW'(1);
                if (new_idx >= cover_idx_t'(COVER_TOTAL)) range_err_d = 1'b1;
            end else if (load) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge gbl_clk) begin
        if (!reset) begin
            pending_q   <= '0;
            reported_q  <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            drop_cnt_q  <= '0;
            range_err_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            pending_q   <= pending_d;
            reported_q  <= reported_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            drop_cnt_q  <= drop_cnt_d;
            range_err_q <= range_err_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign drop_cnt  = drop_cnt_q;
    assign range_err = range_err_q;
    assign busy      = (|pending_q) || out_valid_q;
endmodule

// File: tb/tb_cover_toggle_sched.sv
// Self-checking bench for cover_toggle_sched.
// Table of single-cycle hit patterns plus hand-written multi-cycle sequences.
module tb_cover_toggle_sched;
    logic          gbl_clk = 1'b0;
    logic          reset;
    logic [27:0]   grp_valid;
    logic [255:0]  grp_base;
    logic          clear;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_index;
    logic [15:0]   drop_cnt;
    logic          range_err;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;
    longint unsigned exp_q[$];

    cover_toggle_sched dut (
        .gbl_clk   (gbl_clk),
        .reset     (reset),
        .grp_valid (grp_valid),
        .grp_base  (grp_base),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .drop_cnt  (drop_cnt),
        .range_err (range_err),
        .busy      (busy)
    );

    always #5 gbl_clk = ~gbl_clk;

    task automatic check(input string nm, input longint unsigned act,
                         input longint unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Scoreboard: every accepted beat must match the oldest expected index.
    always @(negedge gbl_clk) begin
        if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: got %0d expected none", out_index);
            end else begin
                longint unsigned e;
                e = exp_q.pop_front();
                if (out_index !== e) begin
                    n_fail++;
                    $display("FAIL beat: got %0d expected %0d", out_index, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge gbl_clk);
        #1;
    endtask

    function automatic logic [27:0] hb(input int g, input int b);
        logic [27:0] v;
        v = '0;
        v[g*7+b] = 1'b1;
        return v;
    endfunction

    task automatic set_bases(input longint unsigned b3);
        grp_base = {b3[63:0], 64'd14, 64'd7, 64'd0};
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        clear     = 1'b0;
        grp_valid = '1;
        repeat (3) step();
        grp_valid = '0;
        reset     = 1'b1;
        step();
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while ((busy || exp_q.size() != 0) && k < 200) begin
            step();
            k++;
        end
        check({nm, "_drained"}, longint'(k < 200 && exp_q.size() == 0), 1);
        exp_q.delete();
    endtask

    typedef struct {
        logic [27:0] hits;
        int          n;
        int          idx[4];
    } vec_t;

    vec_t tbl[5];

    initial begin
        reset = 1'b0; clear = 1'b0; out_ready = 1'b1;
        grp_valid = '0;
        set_bases(64'd21);

        tbl[0] = '{hits: hb(0,3) | hb(2,0), n: 2, idx: '{3, 14, 0, 0}};
        tbl[1] = '{hits: hb(1,6), n: 1, idx: '{13, 0, 0, 0}};
        tbl[2] = '{hits: hb(0,0) | hb(0,1), n: 2, idx: '{0, 1, 0, 0}};
        tbl[3] = '{hits: hb(3,2) | hb(1,0) | hb(1,5), n: 3,
                   idx: '{7, 23, 12, 0}};
        tbl[4] = '{hits: hb(2,1) | hb(0,6), n: 2, idx: '{6, 15, 0, 0}};

        // Reset with hits asserted.
        do_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_range_err", range_err, 0);

        // Latency of a two-group hit.
        grp_valid = hb(0,3) | hb(2,0);
        exp_q.push_back(3); exp_q.push_back(14);
        step(); grp_valid = '0;
        check("lat_t1_valid", out_valid, 0);
        step();
        check("lat_t2_valid", out_valid, 1);
        check("lat_t2_index", out_index, 3);
        step();
        check("lat_t3_index", out_index, 14);
        step();
        check("lat_t4_valid", out_valid, 0);
        drain("lat");

        // Table-driven patterns, each from reset.
        for (int t = 0; t < 5; t++) begin
            do_reset();
            for (int k = 0; k < tbl[t].n; k++) exp_q.push_back(tbl[t].idx[k]);
            grp_valid = tbl[t].hits;
            step(); grp_valid = '0;
            drain($sformatf("tbl%0d", t));
        end

        // All 28 bits, full burst, then deduped repeat.
        begin
            int vcnt;
            do_reset();
            for (int b = 0; b < 7; b++)
                for (int g = 0; g < 4; g++) exp_q.push_back(g*7 + b);
            grp_valid = '1;
            step(); grp_valid = '0;
            vcnt = 0;
            for (int c = 0; c < 28; c++) begin
                step();
                if (out_valid) vcnt++;
            end
            check("burst_consecutive", vcnt, 28);
            step();
            check("burst_end_valid", out_valid, 0);
            drain("burst");
            grp_valid = '1;
            step(); grp_valid = '0;
            check("dedup_busy", busy, 0);
            repeat (4) step();
            check("dedup_valid", out_valid, 0);
        end

        // Backpressure hold and drop counting.
        do_reset();
        out_ready = 1'b0;
        exp_q.push_back(5); exp_q.push_back(9); exp_q.push_back(17);
        grp_valid = hb(0,5) | hb(1,2) | hb(2,3);
        step(); grp_valid = '0;
        step();
        for (int c = 0; c < 10; c++) begin
            check("bp_valid", out_valid, 1);
            check("bp_index", out_index, 5);
            grp_valid = (c == 2 || c == 4) ? hb(1,2) :
                        (c == 6) ? (hb(1,2) | hb(2,3)) : '0;
            step();
        end
        grp_valid = '0;
        check("bp_drop_cnt", drop_cnt, 3);
        out_ready = 1'b1;
        drain("bp");
        check("bp_busy", busy, 0);

        // Range error boundary and stickiness.
        do_reset();
        set_bases(64'd8740);
        exp_q.push_back(8743);
        grp_valid = hb(3,3);
        step(); grp_valid = '0;
        drain("rng_ok");
        check("rng_below", range_err, 0);
        exp_q.push_back(8746);
        grp_valid = hb(3,6);
        step(); grp_valid = '0;
        drain("rng_err");
        check("rng_set", range_err, 1);
        clear = 1'b1; step(); clear = 1'b0; step();
        check("rng_sticky", range_err, 1);
        set_bases(64'd21);

        // Clear with an in-flight beat and pending bits.
        do_reset();
        exp_q.push_back(0);
        grp_valid = hb(0,0);
        step(); grp_valid = '0;
        drain("clr_pre");
        out_ready = 1'b0;
        exp_q.push_back(7);
        grp_valid = hb(0,1) | hb(0,2) | hb(1,0) | hb(1,1) | hb(2,0) | hb(3,0);
        step(); grp_valid = '0;
        step();
        check("clr_loaded", out_index, 7);
        grp_valid = hb(1,1);
        step(); grp_valid = '0;
        check("clr_drop_pre", drop_cnt, 1);
        clear = 1'b1; grp_valid = hb(2,6);
        step(); clear = 1'b0; grp_valid = '0;
        check("clr_drop_zero", drop_cnt, 0);
        check("clr_inflight_valid", out_valid, 1);
        check("clr_inflight_index", out_index, 7);
        out_ready = 1'b1;
        step();
        check("clr_empty_valid", out_valid, 0);
        check("clr_empty_busy", busy, 0);
        exp_q.push_back(0); exp_q.push_back(7);
        grp_valid = hb(0,0) | hb(1,0);
        step(); grp_valid = '0;
        drain("clr_rereport");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
